riscv_wb_stage: RTL

Writeback stage for the RV32I core. It sits between the MEM stage and the register file. It accepts one retiring instruction per handshake and waits for the data-memory response on loads. It sign- or zero-extends and aligns load data, then drives a single-cycle write to the register file. It also counts retired instructions.

---
 rtl/riscv_wb_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_wb_stage.sv
// Writeback stage: takes one retiring instruction per handshake from MEM,
// waits for the data-memory response on loads, extends/aligns load data,
// and issues a single-cycle register-file write. Also counts retirements
// and flags stray memory responses.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | nothing held; ready to accept
// ST_WAIT  | load accepted, waiting for i_dmem_rvalid; not ready
// ST_WRITE | result in holding regs, strobe/retire this cycle; ready
module riscv_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_mem_valid,
  output logic             o_mem_ready,
  input  logic [4:0]       i_mem_rd_addr,
  input  logic             i_mem_rd_wen,
  input  logic [1:0]       i_mem_wb_sel,
  input  logic [31:0]      i_mem_alu_data,
  input  logic [31:0]      i_mem_pc_plus4,
  input  logic [2:0]       i_mem_funct3,
  input  logic [1:0]       i_mem_byte_off,
  input  logic             i_dmem_rvalid,
  input  logic [31:0]      i_dmem_rdata,
  output logic [31:0]      o_regfile_rd_data,
  output logic [4:0]       o_regfile_rd_addr,
  output logic             o_regfile_rd_wen,
  output logic             o_wb_retire,
  output logic [CNT_W-1:0] o_wb_instret,
  output logic             o_wb_err
);

  localparam int XLEN = 32;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             accept_load;
  logic             resp_take;
  logic             in_write;
  logic [XLEN-1:0]  accept_data;
  logic [XLEN-1:0]  load_data;

  logic [4:0]       rd_addr_q;
  logic             rd_wen_q;
  logic [XLEN-1:0]  rd_data_q;
  logic [2:0]       funct3_q;
  logic [1:0]       byte_off_q;
  logic [CNT_W-1:0] instret_q;
  logic             err_q;

  // Pick the addressed byte/halfword out of the raw word and extend it.
  // Unused funct3 encodings fall back to a full-word load.
  function automatic logic [XLEN-1:0] extract_load(
    input logic [2:0]      f3,
    input logic [1:0]      off,
    input logic [XLEN-1:0] word
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'b0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign in_write    = (state == ST_WRITE);
  assign o_mem_ready = (state != ST_WAIT);
  assign accept      = i_mem_valid & o_mem_ready;
  assign accept_load = (i_mem_wb_sel == SEL_LOAD);
  assign resp_take   = (state == ST_WAIT) & i_dmem_rvalid;

  // Result mux for non-load instructions; 00 and 11 both select the ALU.
  always_comb begin
    accept_data = i_mem_alu_data;
    if (i_mem_wb_sel == SEL_PC4) begin
      accept_data = i_mem_pc_plus4;
    end
  end

  // Load data is extracted from the live response using the captured type.
  always_comb begin
    load_data = extract_load(funct3_q, byte_off_q, i_dmem_rdata);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = accept_load ? ST_WAIT : ST_WRITE;
        end
      end
      ST_WAIT: begin
        if (i_dmem_rvalid) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          state_nxt = accept_load ? ST_WAIT : ST_WRITE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Holding registers: loaded at accept, data refilled by the load response.
  // A pending load is dropped on reset because everything clears here.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_addr_q  <= '0;
      rd_wen_q   <= 1'b0;
      rd_data_q  <= '0;
      funct3_q   <= '0;
      byte_off_q <= '0;
    end else if (accept) begin
      rd_addr_q <= i_mem_rd_addr;
      rd_wen_q  <= i_mem_rd_wen;
      if (accept_load) begin
        funct3_q   <= i_mem_funct3;
        byte_off_q <= i_mem_byte_off;
      end else begin
        rd_data_q <= accept_data;
      end
    end else if (resp_take) begin
      rd_data_q <= load_data;
    end
  end

  // Retired-instruction counter; wraps naturally at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      instret_q <= '0;
    end else if (in_write) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Sticky error: any response arriving when no load is outstanding.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      err_q <= 1'b0;
    end else if (i_dmem_rvalid && (state != ST_WAIT)) begin
      err_q <= 1'b1;
    end
  end

  // Output drive; x0 writes retire but never strobe the register file.
  always_comb begin
    o_regfile_rd_data = rd_data_q;
    o_regfile_rd_addr = rd_addr_q;
    o_regfile_rd_wen  = in_write & rd_wen_q & (rd_addr_q != 5'd0);
    o_wb_retire       = in_write;
    o_wb_instret      = instret_q;
    o_wb_err          = err_q;
  end

endmodule
